// File: rtl/zxuno_strwr_pkg.sv
// Shared constants and state encoding for the ZX-UNO string-write register.
// Imported by the bank and the top level.
package zxuno_strwr_pkg;

   localparam logic [7:0]  DEF_REGADDR = 8'hF9;
   localparam int unsigned DEF_LEN     = 16;
   localparam logic [7:0]  NUL         = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WRITING = 2'd1,
      ST_DONE    = 2'd2
   } strwr_state_t;

   function automatic logic is_nul_byte(input logic [7:0] b);
      return b == NUL;
   endfunction

endpackage

// File: rtl/zxuno_strwr_bank.sv
// Shadow and committed character arrays: byte write into shadow, single-edge
// bulk copy shadow->committed, and a registered read of the committed array.
module strwr_bank
   import zxuno_strwr_pkg::*;
#(
   parameter int unsigned LEN = DEF_LEN,
   parameter int unsigned AW  = $clog2(LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          copy,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] shadow    [LEN];
   logic [7:0] committed [LEN];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LEN; i++) begin
            shadow[i]    <= '0;
            committed[i] <= '0;
         end
      end else begin
         if (wr_en)
            shadow[wr_addr] <= wr_data;
         // Copy sees the shadow as it stood before this edge.
         if (copy)
            for (int unsigned i = 0; i < LEN; i++)
               committed[i] <= shadow[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else
         rd_data <= committed[rd_addr];
   end

endmodule

// File: rtl/zxuno_strwr.sv
// ZX-UNO string-write register: collects bytes written to REGADDR and commits
// the whole string atomically on NUL or on the LEN-th character.
module zxuno_strwr
   import zxuno_strwr_pkg::*;
#(
   parameter logic [7:0]  REGADDR = DEF_REGADDR,
   parameter int unsigned LEN     = DEF_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             zxuno_addr,
   input  logic                   zxuno_regwr,
   input  logic [7:0]             din,
   input  logic                   regaddr_changed,
   input  logic [$clog2(LEN)-1:0] rd_addr,
   output logic [7:0]             rd_data,
   output logic [$clog2(LEN):0]   str_len,
   output logic                   str_valid,
   output logic                   commit,
   output logic                   overflow
);

   localparam int unsigned AW = $clog2(LEN);
   localparam int unsigned PW = AW + 1;

   strwr_state_t  state, state_n;
   logic [PW-1:0] ptr;
   logic          is_nul;

   logic          wr_act, restart;
   logic          cap, do_commit, ptr_inc, set_ovf;
   logic [PW-1:0] commit_len;

   assign wr_act  = (zxuno_addr == REGADDR) && zxuno_regwr;
   assign restart = regaddr_changed && (zxuno_addr == REGADDR);

   always_comb begin
      state_n    = state;
      cap        = 1'b0;
      do_commit  = 1'b0;
      ptr_inc    = 1'b0;
      set_ovf    = 1'b0;
      commit_len = ptr;
      if (restart) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (wr_act) begin
                  cap     = 1'b1;
                  state_n = ST_WRITING;
               end
            end
            ST_WRITING: begin
               if (!wr_act) begin
                  if (is_nul) begin
                     do_commit  = 1'b1;
                     commit_len = ptr;
                     state_n    = ST_DONE;
                  end else if (ptr == PW'(LEN - 1)) begin
                     do_commit  = 1'b1;
                     commit_len = PW'(LEN);
                     state_n    = ST_DONE;
                  end else begin
                     ptr_inc = 1'b1;
                     state_n = ST_IDLE;
                  end
               end
            end
            ST_DONE: begin
               if (wr_act)
                  set_ovf = 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         is_nul    <= 1'b0;
         str_len   <= '0;
         str_valid <= 1'b0;
         commit    <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         commit <= do_commit;
         if (restart) begin
            ptr      <= '0;
            overflow <= 1'b0;
         end else begin
            if (ptr_inc)
               ptr <= ptr + 1'b1;
            if (set_ovf)
               overflow <= 1'b1;
         end
         if (cap)
            is_nul <= is_nul_byte(din);
         if (do_commit) begin
            str_len   <= commit_len;
            str_valid <= 1'b1;
         end
      end
   end

   strwr_bank #(
      .LEN (LEN),
      .AW  (AW)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cap),
      .wr_addr (ptr[AW-1:0]),
      .wr_data (din),
      .copy    (do_commit),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
